// File: rtl/reg_file.sv
// Architectural register file with rename tags: 32 values, busy bits and ROB tags, two query ports.
// Optional macro RF_BYPASS_EN forwards a same-cycle qualifying commit to the query ports.
module reg_file #(
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [31:0]             update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_id,
  input  logic [4:0]              qry2_id,
  output logic [31:0]             qry1_value,
  output logic [31:0]             qry2_value,
  output logic                    qry1_has_dep,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep
);

  logic [31:0]             value_q [32];
  logic                    busy_q  [32];
  logic [ROB_SIZE_BIT-1:0] tag_q   [32];

  logic commit_ok;
  logic commit_clears;
  logic rename_ok;

  assign commit_ok     = is_update_val && (update_val_id != 5'd0);
  assign commit_clears = commit_ok && busy_q[update_val_id] &&
                         (tag_q[update_val_id] == update_val_dep);
  assign rename_ok     = is_update_dep && (update_dep_id != 5'd0);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < 32; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else begin
        if (commit_ok) begin
          value_q[update_val_id] <= update_val;
          if (commit_clears) busy_q[update_val_id] <= 1'b0;
        end
        // Rename is issued last so it overrides a same-register commit.
        if (rename_ok) begin
          busy_q[update_dep_id] <= 1'b1;
          tag_q[update_dep_id]  <= update_dep;
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = rdy_in && !rob_clear && commit_clears;
`endif

  always_comb begin
    qry1_value   = value_q[qry1_id];
    qry1_has_dep = busy_q[qry1_id];
    qry1_dep     = tag_q[qry1_id];
    qry2_value   = value_q[qry2_id];
    qry2_has_dep = busy_q[qry2_id];
    qry2_dep     = tag_q[qry2_id];
`ifdef RF_BYPASS_EN
    if (bypass_ok && (qry1_id == update_val_id)) begin
      qry1_value   = update_val;
      qry1_has_dep = 1'b0;
    end
    if (bypass_ok && (qry2_id == update_val_id)) begin
      qry2_value   = update_val;
      qry2_has_dep = 1'b0;
    end
`endif
    if (qry1_id == 5'd0) begin
      qry1_value   = '0;
      qry1_has_dep = 1'b0;
      qry1_dep     = '0;
    end
    if (qry2_id == 5'd0) begin
      qry2_value   = '0;
      qry2_has_dep = 1'b0;
      qry2_dep     = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: rename/commit, stale tags, flush, x0 and stall behaviour.
module tb_reg_file;
  localparam int RB = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_clear;
  logic          is_update_val;
  logic [4:0]    update_val_id;
  logic [RB-1:0] update_val_dep;
  logic [31:0]   update_val;
  logic          is_update_dep;
  logic [4:0]    update_dep_id;
  logic [RB-1:0] update_dep;
  logic [4:0]    qry1_id, qry2_id;
  logic [31:0]   qry1_value, qry2_value;
  logic          qry1_has_dep, qry2_has_dep;
  logic [RB-1:0] qry1_dep, qry2_dep;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.ROB_SIZE_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .qry1_id(qry1_id), .qry2_id(qry2_id),
    .qry1_value(qry1_value), .qry2_value(qry2_value),
    .qry1_has_dep(qry1_has_dep), .qry2_has_dep(qry2_has_dep),
    .qry1_dep(qry1_dep), .qry2_dep(qry2_dep)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    rob_clear = 0; is_update_val = 0; update_val_id = 0; update_val_dep = 0; update_val = 0;
    is_update_dep = 0; update_dep_id = 0; update_dep = 0;
  endtask

  // One clock edge; inputs drop back to idle 1 ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst_in = 0; rdy_in = 1; idle();
    qry1_id = 5; qry2_id = 0;
    step(); step();
    rst_in = 1;
    #1;
    n_checks++;
    if ({qry1_value, qry1_has_dep, qry1_dep} !== {32'h0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_x5: got %h/%b/%0d want 0/0/0", qry1_value, qry1_has_dep, qry1_dep);
    end
    n_checks++;
    if ({qry2_value, qry2_has_dep, qry2_dep} !== {32'h0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_x0: got %h/%b/%0d want 0/0/0", qry2_value, qry2_has_dep, qry2_dep);
    end
  endtask

  task automatic test_rename_commit();
    is_update_dep = 1; update_dep_id = 5; update_dep = 3;
    qry1_id = 5;
    #1;
    n_checks++;
    if (qry1_has_dep !== 1'b0) begin
      n_fail++; $display("FAIL rename_not_same_cycle: has_dep got %b want 0", qry1_has_dep);
    end
    step();
    n_checks++;
    if ({qry1_has_dep, qry1_dep} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL rename_x5: got %b/%0d want 1/3", qry1_has_dep, qry1_dep);
    end
    is_update_val = 1; update_val_id = 5; update_val_dep = 3; update_val = 32'hDEADBEEF;
    step();
    n_checks++;
    if ({qry1_value, qry1_has_dep} !== {32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL commit_x5: got %h/%b want deadbeef/0", qry1_value, qry1_has_dep);
    end
  endtask

  task automatic test_stale_commit();
    is_update_dep = 1; update_dep_id = 7; update_dep = 2; step();
    is_update_dep = 1; update_dep_id = 7; update_dep = 9; step();
    is_update_val = 1; update_val_id = 7; update_val_dep = 2; update_val = 32'h11; step();
    qry2_id = 7;
    #1;
    n_checks++;
    if ({qry2_value, qry2_has_dep, qry2_dep} !== {32'h11, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL stale_commit_x7: got %h/%b/%0d want 11/1/9", qry2_value, qry2_has_dep, qry2_dep);
    end
  endtask

  task automatic test_same_cycle();
    is_update_dep = 1; update_dep_id = 4; update_dep = 6; step();
    is_update_val = 1; update_val_id = 4; update_val_dep = 6; update_val = 32'h22;
    is_update_dep = 1; update_dep_id = 4; update_dep = 10;
    qry1_id = 4;
    #1;
    n_checks++;
`ifdef RF_BYPASS_EN
    if ({qry1_value, qry1_has_dep} !== {32'h22, 1'b0}) begin
      n_fail++; $display("FAIL bypass_x4: got %h/%b want 22/0", qry1_value, qry1_has_dep);
    end
`else
    if ({qry1_value, qry1_has_dep, qry1_dep} !== {32'h0, 1'b1, 5'd6}) begin
      n_fail++; $display("FAIL no_bypass_x4: got %h/%b/%0d want 0/1/6", qry1_value, qry1_has_dep, qry1_dep);
    end
`endif
    step();
    n_checks++;
    if ({qry1_value, qry1_has_dep, qry1_dep} !== {32'h22, 1'b1, 5'd10}) begin
      n_fail++; $display("FAIL rename_wins_x4: got %h/%b/%0d want 22/1/10", qry1_value, qry1_has_dep, qry1_dep);
    end
  endtask

  task automatic test_clear();
    logic [4:0] idx;
    is_update_val = 1; update_val_id = 3; update_val_dep = 0; update_val = 32'h33; step();
    for (int i = 1; i < 32; i++) begin
      idx = 5'(i);
      is_update_dep = 1; update_dep_id = idx; update_dep = idx; step();
    end
    qry1_id = 31; qry2_id = 17;
    #1;
    n_checks++;
    if ({qry1_has_dep, qry1_dep, qry2_has_dep, qry2_dep} !== {1'b1, 5'd31, 1'b1, 5'd17}) begin
      n_fail++; $display("FAIL rename_all: got %b/%0d %b/%0d want 1/31 1/17", qry1_has_dep, qry1_dep, qry2_has_dep, qry2_dep);
    end
    rob_clear = 1;
    is_update_val = 1; update_val_id = 3; update_val_dep = 3; update_val = 32'h55;
    is_update_dep = 1; update_dep_id = 9; update_dep = 4;
    step();
    for (int i = 1; i < 32; i++) begin
      idx = 5'(i);
      qry1_id = idx;
      #1;
      n_checks++;
      if ({qry1_has_dep, qry1_dep} !== {1'b0, 5'd0}) begin
        n_fail++; $display("FAIL clear_x%0d: got %b/%0d want 0/0", i, qry1_has_dep, qry1_dep);
      end
    end
    qry1_id = 3; qry2_id = 5;
    #1;
    n_checks++;
    if ({qry1_value, qry2_value} !== {32'h33, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL clear_keeps_values: got %h %h want 33 deadbeef", qry1_value, qry2_value);
    end
  endtask

  task automatic test_x0_and_stall();
    is_update_val = 1; update_val_id = 0; update_val_dep = 7; update_val = 32'h99;
    is_update_dep = 1; update_dep_id = 0; update_dep = 7;
    step();
    qry1_id = 0;
    #1;
    n_checks++;
    if ({qry1_value, qry1_has_dep, qry1_dep} !== {32'h0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL x0_const: got %h/%b/%0d want 0/0/0", qry1_value, qry1_has_dep, qry1_dep);
    end
    is_update_dep = 1; update_dep_id = 10; update_dep = 12; step();
    rdy_in = 0;
    is_update_dep = 1; update_dep_id = 8; update_dep = 5; step();
    is_update_val = 1; update_val_id = 5; update_val_dep = 0; update_val = 32'h1; step();
    rob_clear = 1; step();
    qry1_id = 8; qry2_id = 10;
    #1;
    n_checks++;
    if (qry1_has_dep !== 1'b0) begin
      n_fail++; $display("FAIL stall_rename_x8: has_dep got %b want 0", qry1_has_dep);
    end
    n_checks++;
    if ({qry2_has_dep, qry2_dep} !== {1'b1, 5'd12}) begin
      n_fail++; $display("FAIL stall_clear_x10: got %b/%0d want 1/12", qry2_has_dep, qry2_dep);
    end
    qry1_id = 5;
    #1;
    n_checks++;
    if (qry1_value !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stall_commit_x5: got %h want deadbeef", qry1_value);
    end
    rdy_in = 1;
  endtask

  task automatic test_reset_override();
    rst_in = 0; rdy_in = 0; rob_clear = 1;
    is_update_dep = 1; update_dep_id = 6; update_dep = 3;
    is_update_val = 1; update_val_id = 5; update_val_dep = 0; update_val = 32'h7;
    step();
    rst_in = 1; rdy_in = 1;
    qry1_id = 5; qry2_id = 10;
    #1;
    n_checks++;
    if ({qry1_value, qry1_has_dep, qry2_value, qry2_has_dep, qry2_dep} !==
        {32'h0, 1'b0, 32'h0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_override: got %h/%b %h/%b/%0d want 0/0 0/0/0",
                         qry1_value, qry1_has_dep, qry2_value, qry2_has_dep, qry2_dep);
    end
  endtask

  initial begin
    idle();
    rst_in = 0; rdy_in = 1; qry1_id = 0; qry2_id = 0;
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_clear();
    test_x0_and_stall();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_SIZE_BIT, default 5, width of ROB tags (32-entry ROB).
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_in  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rdy_in  input  1  ready; low freezes all state.
REQ-005 SHALL have port rob_clear  input  1  mispredict flush from ROB.
REQ-006 SHALL have port is_update_val  input  1  ROB commit strobe.
REQ-007 SHALL have port update_val_id  input  5  committed rd index.
REQ-008 SHALL have port update_val_dep  input  ROB_SIZE_BIT  ROB tag of committing entry.
REQ-009 SHALL have port update_val  input  32  committed value.
REQ-010 SHALL have port is_update_dep  input  1  rename strobe from dispatch.
REQ-011 SHALL have port update_dep_id  input  5  renamed rd index.
REQ-012 SHALL have port update_dep  input  ROB_SIZE_BIT  ROB tag now owning rd.
REQ-013 SHALL have ports qry1_id, qry2_id  input  5 each  source register indices from Decoder.
REQ-014 SHALL have ports qry1_value, qry2_value  output  32 each  architectural value.
REQ-015 SHALL have ports qry1_has_dep, qry2_has_dep  output  1 each  register awaits an in-flight ROB entry.
REQ-016 SHALL have ports qry1_dep, qry2_dep  output  ROB_SIZE_BIT each  owning ROB tag, valid when has_dep=1.

Function
REQ-017 SHALL hold 32 x 32-bit values, 32 busy bits, 32 ROB_SIZE_BIT-bit tags.
REQ-018 SHALL treat x0 as constant: value 0, busy 0, tag 0; commits and renames to index 0 ignored.
REQ-019 SHALL, on commit (is_update_val=1, id!=0), write update_val into value[id] at next edge, regardless of tag.
REQ-020 SHALL clear busy[id] on commit only if busy[id]=1 and tag[id]==update_val_dep; a stale tag leaves busy/tag untouched.
REQ-021 SHALL, on rename (is_update_dep=1, id!=0), set busy[id]=1 and tag[id]=update_dep at next edge.
REQ-022 SHALL, on commit and rename to the same register in one cycle, write the value and leave busy=1 with the new rename tag (rename wins).
REQ-023 SHALL, when rob_clear=1, clear all busy bits and tags to 0, retain all values, and ignore commit and rename that cycle.
REQ-024 SHALL drive query outputs combinationally from current state: value[id], busy[id], tag[id]; index 0 returns 0/0/0.
REQ-025 SHALL NOT reflect a same-cycle rename in query outputs (rs==rd of the dispatching instruction reads old owner).
REQ-026 SHALL, when rdy_in=0, ignore all updates and clears; query outputs still track state.
REQ-027 SHALL expose no pipelining: commit/rename latency is exactly one edge.

Reset
REQ-028 SHALL, on rising edge with rst_in=0, zero all values, busy bits and tags, regardless of rdy_in, rob_clear or strobes.
REQ-029 SHALL, after reset, return qryN_value=0, qryN_has_dep=0, qryN_dep=0 for every index.

Configuration
REQ-030 SHALL, with RF_BYPASS_EN defined, forward a same-cycle qualifying commit (REQ-020 tag match, id!=0, rob_clear=0, rdy_in=1) to a matching query: qryN_value=update_val, qryN_has_dep=0, unless a same-cycle rename... (rename not visible per REQ-025).
REQ-031 SHALL, without RF_BYPASS_EN, present only registered state; committed value visible one cycle after commit.

Verification
REQ-032 Reset then query x5 -> value 0, has_dep 0, dep 0.
REQ-033 Rename x5 tag 3; next cycle query x5 -> has_dep 1, dep 3; commit x5 tag 3 value 0xDEADBEEF -> next cycle has_dep 0, value 0xDEADBEEF.
REQ-034 Rename x7 tag 2, then rename x7 tag 9, then commit x7 tag 2 value 0x11 -> value 0x11, has_dep 1, dep 9.
REQ-035 Same cycle commit x4 tag 6 (owner 6) value 0x22 and rename x4 tag 10 -> value 0x22, has_dep 1, dep 10; with RF_BYPASS_EN query x4 in commit cycle -> value 0x22, has_dep 0.
REQ-036 Rename x1..x31 tags 1..31, assert rob_clear with commit x3 value 0x55 -> all has_dep 0, x3 value unchanged.
REQ-037 Rename/commit to x0 value 0x99, and rdy_in=0 during rename of x8 -> x0 reads 0/0; x8 stays has_dep 0.
